btn_gesture_decoder: RTL and testbench

- Sits between the button debouncer and the LED/exercise logic.
- Consumes the synchronized, debounced active-low button level and classifies presses into single-cycle event pulses: short press, long press, double click, and auto-repeat while held.
- Also emits a registered "pressed" level, so downstream logic reacts to gestures instead of raw levels.

---
 rtl/btn_gesture_decoder.sv | 117 +++++++++++
 tb/tb_btn_gesture_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btn_gesture_decoder.sv
// Classifies a debounced active-low button into short/long/double/repeat pulses.
// All outputs are registered; event pulses last one cycle and never overlap.
module btn_gesture_decoder #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int RPT_CYCLES  = 10_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic short_o,
    output logic long_o,
    output logic double_o,
    output logic repeat_o
);

    localparam longint MAX_A = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam longint MAX_P = (MAX_A > RPT_CYCLES) ? MAX_A : RPT_CYCLES;

    if (MAX_P >= (longint'(1) << CNT_W)) begin : g_cnt_w_err
        $error("btn_gesture_decoder: CNT_W too small for cycle parameters");
    end

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(RPT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             short_nx, long_nx, double_nx, repeat_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!btn_n_i) state_nx = PRESS1;
            end
            // release is tested first so it beats a coincident threshold
            PRESS1: begin
                if (btn_n_i) begin
                    state_nx = GAP;
                end else if (cnt == LONG_M1) begin
                    long_nx  = 1'b1;
                    state_nx = HELD;
                end
            end
            GAP: begin
                if (!btn_n_i) begin
                    state_nx = PRESS2;
                end else if (cnt == GAP_M1) begin
                    short_nx = 1'b1;
                    state_nx = IDLE;
                end
            end
            PRESS2: begin
                cnt_nx = '0;
                if (btn_n_i) begin
                    double_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
            HELD: begin
                if (btn_n_i) begin
                    state_nx = IDLE;
                end else if (cnt == RPT_M1) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (state_nx != state) cnt_nx = '0;
        if (!en_i) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            short_nx  = 1'b0;
            long_nx   = 1'b0;
            double_nx = 1'b0;
            repeat_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            pressed_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            double_o  <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pressed_o <= !btn_n_i;
            short_o   <= short_nx;
            long_o    <= long_nx;
            double_o  <= double_nx;
            repeat_o  <= repeat_nx;
        end
    end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed-vector bench for btn_gesture_decoder with small cycle parameters.
// Pulse times are edge indices counted from the last clr_log call.
module tb_btn_gesture_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic btn_n = 1'b1;
    logic pressed, short_p, long_p, double_p, repeat_p;

    int errors = 0;
    int checks = 0;

    int e;
    int n_short, n_long, n_double, n_rpt, n_multi;
    int t_short, t_long, t_double, t_rpt_first, t_rpt_last;

    btn_gesture_decoder #(
        .LONG_CYCLES(10), .GAP_CYCLES(5), .RPT_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .btn_n_i(btn_n),
        .pressed_o(pressed), .short_o(short_p), .long_o(long_p),
        .double_o(double_p), .repeat_o(repeat_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        e = 0;
        n_short = 0; n_long = 0; n_double = 0; n_rpt = 0; n_multi = 0;
        t_short = -1; t_long = -1; t_double = -1; t_rpt_first = -1; t_rpt_last = -1;
    endtask

    // drive btn for n edges, logging every pulse after each edge
    task automatic run(input logic b, input int n);
        btn_n = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (short_p)  begin n_short++;  t_short  = e; end
            if (long_p)   begin n_long++;   t_long   = e; end
            if (double_p) begin n_double++; t_double = e; end
            if (repeat_p) begin
                n_rpt++;
                if (t_rpt_first < 0) t_rpt_first = e;
                t_rpt_last = e;
            end
            if (int'(short_p) + int'(long_p) + int'(double_p) + int'(repeat_p) > 1) n_multi++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        run(1'b1, 2);
        rst = 1'b0;
    endtask

    function automatic int outs();
        return int'({pressed, short_p, long_p, double_p, repeat_p});
    endfunction

    initial begin
        clr_log();

        // reset held with button low: everything stays 0
        rst = 1'b1;
        btn_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outs", outs(), 0);
        end
        rst = 1'b0;
        run(1'b0, 1);
        chk("reset_release_pressed", int'(pressed), 1);

        // short press: 3 low, release
        do_reset();
        clr_log();
        run(1'b0, 3);
        run(1'b1, 10);
        chk("short_count", n_short, 1);
        chk("short_time", t_short, 9);
        chk("short_no_long", n_long, 0);
        chk("short_no_double", n_double, 0);

        // long press with repeat
        do_reset();
        clr_log();
        run(1'b0, 25);
        chk("long_pressed", int'(pressed), 1);
        run(1'b1, 10);
        chk("long_count", n_long, 1);
        chk("long_time", t_long, 11);
        chk("rpt_count", n_rpt, 3);
        chk("rpt_first", t_rpt_first, 15);
        chk("rpt_last", t_rpt_last, 23);
        chk("long_no_short", n_short, 0);
        chk("long_pressed_release", int'(pressed), 0);

        // double click with a long second press
        do_reset();
        clr_log();
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 20);
        run(1'b1, 10);
        chk("dbl_count", n_double, 1);
        chk("dbl_time", t_double, 26);
        chk("dbl_no_short", n_short, 0);
        chk("dbl_no_long", n_long, 0);
        chk("dbl_no_rpt", n_rpt, 0);

        // release on the 11th sample: no long, short follows
        do_reset();
        clr_log();
        run(1'b0, 10);
        run(1'b1, 8);
        chk("bnd_long_none", n_long, 0);
        chk("bnd_short_count", n_short, 1);
        chk("bnd_short_time", t_short, 16);

        // second press on the final gap cycle wins over short
        do_reset();
        clr_log();
        run(1'b0, 3);
        run(1'b1, 5);
        run(1'b0, 2);
        run(1'b1, 8);
        chk("bnd_gap_no_short", n_short, 0);
        chk("bnd_gap_double", n_double, 1);
        chk("bnd_gap_dtime", t_double, 11);

        // enable dropped mid-press: no pulses, pressed still tracks
        do_reset();
        clr_log();
        run(1'b0, 5);
        en = 1'b0;
        run(1'b0, 3);
        chk("en_pressed", int'(pressed), 1);
        run(1'b1, 12);
        chk("en_pressed_rel", int'(pressed), 0);
        chk("en_no_pulses", n_short + n_long + n_double + n_rpt, 0);

        // re-enable with button already low: fresh press
        run(1'b0, 2);
        en = 1'b1;
        clr_log();
        run(1'b0, 3);
        run(1'b1, 10);
        chk("reen_short_time", t_short, 9);
        chk("reen_short_count", n_short, 1);

        // reset in HELD, on the edge a repeat would have fired
        do_reset();
        clr_log();
        run(1'b0, 14);
        chk("held_long", n_long, 1);
        rst = 1'b1;
        run(1'b0, 1);
        chk("rst_held_outs", outs(), 0);
        run(1'b0, 1);
        chk("rst_held_outs2", outs(), 0);
        rst = 1'b0;
        run(1'b1, 10);
        chk("rst_held_no_rpt", n_rpt, 0);
        chk("rst_held_no_short", n_short + n_double, 0);
        chk("multi_pulse", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
